// File: rtl/pcie_cv_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the PCIe TXS
// requester arbiter and its outstanding-read queue.
package pcie_cv_pkg;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned BURST_W_DEF   = 6;
    localparam int unsigned RDQ_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ARB,
        CMD,
        WBURST
    } arb_state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcie_txs_arbiter_if.sv
// Bundle of the requester-side Avalon-MM buses and the downstream TXS slave bus.
// slave = arbiter view, master = environment (requesters + TXS) view.
interface pcie_txs_arbiter_if
    import pcie_cv_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
);

    logic [NREQ*ADDR_W-1:0]     rq_address;
    logic [NREQ*DATA_W-1:0]     rq_writedata;
    logic [NREQ*DATA_W/8-1:0]   rq_byteenable;
    logic [NREQ*BURST_W-1:0]    rq_burstcount;
    logic [NREQ-1:0]            rq_read;
    logic [NREQ-1:0]            rq_write;
    logic [NREQ-1:0]            rq_waitrequest;
    logic [NREQ-1:0]            rq_readdatavalid;
    logic [DATA_W-1:0]          rq_readdata;

    logic [ADDR_W-1:0]          txs_address;
    logic [DATA_W-1:0]          txs_writedata;
    logic [DATA_W/8-1:0]        txs_byteenable;
    logic [BURST_W-1:0]         txs_burstcount;
    logic                       txs_read;
    logic                       txs_write;
    logic                       txs_waitrequest;
    logic                       txs_readdatavalid;
    logic [DATA_W-1:0]          txs_readdata;

    modport slave (
        input  rq_address, rq_writedata, rq_byteenable, rq_burstcount, rq_read, rq_write,
        output rq_waitrequest, rq_readdatavalid, rq_readdata,
        output txs_address, txs_writedata, txs_byteenable, txs_burstcount, txs_read, txs_write,
        input  txs_waitrequest, txs_readdatavalid, txs_readdata
    );

    modport master (
        output rq_address, rq_writedata, rq_byteenable, rq_burstcount, rq_read, rq_write,
        input  rq_waitrequest, rq_readdatavalid, rq_readdata,
        input  txs_address, txs_writedata, txs_byteenable, txs_burstcount, txs_read, txs_write,
        output txs_waitrequest, txs_readdatavalid, txs_readdata
    );

endinterface

// File: rtl/pcie_rdq_fifo.sv
// Outstanding-read queue: FIFO of {requester id, burstcount} whose head is
// retired by counting response beats against the stored burst length.
module pcie_rdq_fifo #(
    parameter int unsigned ID_W    = 2,
    parameter int unsigned BURST_W = 6,
    parameter int unsigned DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [ID_W-1:0]    i_push_id,
    input  logic [BURST_W-1:0] i_push_burst,
    input  logic               i_beat,
    output logic               o_full,
    output logic               o_empty,
    output logic [ID_W-1:0]    o_head_id
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W+BURST_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic [BURST_W-1:0]      r_head_done;
    logic [BURST_W-1:0]      w_head_burst;
    logic                    w_push;
    logic                    w_beat;
    logic                    w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign {o_head_id, w_head_burst} = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_beat = i_beat & ~o_empty;
    // Stored bursts are already normalised to >= 1, so the last beat is done == burst-1.
    assign w_pop  = w_beat & (r_head_done == w_head_burst - BURST_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head_done <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (w_beat)
                r_head_done <= w_pop ? '0 : r_head_done + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {i_push_id, i_push_burst};
    end

endmodule

// File: rtl/pcie_txs_arbiter.sv
// Round-robin arbiter multiplexing NREQ Avalon-MM requesters onto one PCIe
// HIP TXS slave; write bursts hold the grant, read responses are steered in order.
module pcie_txs_arbiter
    import pcie_cv_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_W   = BURST_W_DEF,
    parameter int unsigned RDQ_DEPTH = RDQ_DEPTH_DEF
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    pcie_txs_arbiter_if.slave   bus,
    output logic                err_unexpected_rd
);

    localparam int unsigned ID_W = id_width(NREQ);
    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [ID_W-1:0]    r_grant;
    logic [ID_W-1:0]    w_pick;
    logic               w_found;
    logic [BURST_W-1:0] r_remaining;
    logic [BURST_W-1:0] w_burst;
    logic [BURST_W-1:0] w_burst_eff;
    logic [NREQ-1:0]    w_elig;
    logic               w_full;
    logic               w_empty;
    logic [ID_W-1:0]    w_head_id;
    logic               w_active;
    logic               w_acc;
    logic               w_push;
    logic               w_rsp;
    logic               r_err;

    assign w_active = (r_state != ARB);
    assign w_elig   = bus.rq_write | (bus.rq_read & {NREQ{~w_full}});

    assign bus.txs_address    = bus.rq_address[r_grant*ADDR_W +: ADDR_W];
    assign bus.txs_writedata  = bus.rq_writedata[r_grant*DATA_W +: DATA_W];
    assign bus.txs_byteenable = bus.rq_byteenable[r_grant*BE_W +: BE_W];
    assign bus.txs_burstcount = bus.rq_burstcount[r_grant*BURST_W +: BURST_W];
    assign bus.txs_read       = (r_state == CMD) & bus.rq_read[r_grant];
    assign bus.txs_write      = w_active & bus.rq_write[r_grant];
    assign bus.rq_readdata    = bus.txs_readdata;

    assign w_burst     = bus.txs_burstcount;
    assign w_burst_eff = (w_burst == '0) ? BURST_W'(1) : w_burst;
    assign w_acc       = (bus.txs_read | bus.txs_write) & ~bus.txs_waitrequest;
    assign w_rsp       = bus.txs_readdatavalid & ~w_empty;

    assign err_unexpected_rd = r_err;

    // Search starts one past the last grant, so r_grant doubles as last_grant.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_grant;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!w_found && w_elig[(32'(r_grant) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = ID_W'((32'(r_grant) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            ARB: begin
                if (w_found)
                    w_next_state = CMD;
            end
            CMD: begin
                if (w_acc) begin
                    if (bus.txs_read) begin
                        w_push       = 1'b1;
                        w_next_state = ARB;
                    end else if (w_burst_eff == BURST_W'(1)) begin
                        w_next_state = ARB;
                    end else begin
                        w_next_state = WBURST;
                    end
                end
            end
            WBURST: begin
                if (w_acc && r_remaining == BURST_W'(1))
                    w_next_state = ARB;
            end
            default: w_next_state = ARB;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= ARB;
            r_grant     <= ID_W'(NREQ - 1);
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ARB && w_found)
                r_grant <= w_pick;
            if (r_state == CMD && w_acc && !bus.txs_read)
                r_remaining <= w_burst_eff - BURST_W'(1);
            else if (r_state == WBURST && w_acc)
                r_remaining <= r_remaining - BURST_W'(1);
            if (bus.txs_readdatavalid && w_empty)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        bus.rq_waitrequest   = '1;
        bus.rq_readdatavalid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_active && !bus.txs_waitrequest && (r_grant == ID_W'(i)))
                bus.rq_waitrequest[i] = 1'b0;
            if (w_rsp && (w_head_id == ID_W'(i)))
                bus.rq_readdatavalid[i] = 1'b1;
        end
    end

    pcie_rdq_fifo #(
        .ID_W    (ID_W),
        .BURST_W (BURST_W),
        .DEPTH   (RDQ_DEPTH)
    ) u_rdq (
        .clk          (clk_clk),
        .rst_n        (reset_reset_n),
        .i_push       (w_push),
        .i_push_id    (r_grant),
        .i_push_burst (w_burst_eff),
        .i_beat       (bus.txs_readdatavalid),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head_id    (w_head_id)
    );

endmodule
